// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, reads instructions over the shared bus
// and loads the IF/ID pipeline register consumed by the decoder.
module if_fetch_stage #(
  parameter logic [29:0] RESET_VECTOR = 30'h0,
  parameter logic [31:0] NOP_INSN     = 32'h0
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] new_pc,
  input  logic        br_taken,
  input  logic [29:0] br_addr,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  input  logic        bus_rdy_,
  input  logic [31:0] bus_rd_data,
  output logic        busy,
  output logic [29:0] if_pc,
  output logic [31:0] if_insn,
  output logic        if_en
);

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        done;
  logic        transfer;
  logic [31:0] xfer_data;
  logic [31:0] insn_buf;

  // Next-state logic; flush overrides everything and drops any response in flight.
  always_comb begin
    next_state = state;
    done       = (state == ACCESS) && !bus_rdy_;
    transfer   = 1'b0;
    xfer_data  = bus_rd_data;
    if (flush) begin
      next_state = REQ;
    end else begin
      case (state)
        REQ: begin
          if (!bus_grnt_) next_state = ACCESS;
        end
        ACCESS: begin
          if (done) begin
            if (!stall) begin
              transfer   = 1'b1;
              next_state = bus_grnt_ ? REQ : ACCESS;
            end else begin
              next_state = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            transfer   = 1'b1;
            xfer_data  = insn_buf;
            next_state = REQ;
          end
        end
        default: next_state = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= REQ;
    else         state <= next_state;
  end

  // A completed read that arrives while the pipe is stalled is parked here.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)                          insn_buf <= 32'h0;
    else if (flush)                       insn_buf <= 32'h0;
    else if (done && stall)               insn_buf <= bus_rd_data;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      if_pc   <= RESET_VECTOR;
      if_insn <= NOP_INSN;
      if_en   <= 1'b0;
    end else if (flush) begin
      if_pc   <= new_pc;
      if_insn <= NOP_INSN;
      if_en   <= 1'b0;
    end else if (transfer) begin
      if_pc   <= br_taken ? br_addr : if_pc + 30'd1;
      if_insn <= xfer_data;
      if_en   <= 1'b1;
    end
  end

  // The request is masked while reset is held so the bus sees an idle master.
  assign bus_req_ = !reset_ || (state == HOLD);
  assign bus_as_  = (state != ACCESS);
  assign bus_rw   = 1'b1;
  assign bus_addr = if_pc;
  assign busy     = !done && (state != HOLD);

endmodule
